// File: rtl/tpu_mem_pkg.sv
// Shared types and sizing helpers for the banked window memory and its
// address generator.
package tpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_NUM_UNITS    = 2;
    localparam int DEF_IMAGE_WIDTH  = 8;
    localparam int DEF_IMAGE_HEIGHT = 8;
    localparam int DEF_ADDR_W       = addr_w(DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT);

    typedef logic [DEF_NUM_UNITS-1:0][DEF_DATA_WIDTH-1:0] data_vec_t;
    typedef logic [DEF_NUM_UNITS-1:0][DEF_ADDR_W-1:0]     addr_vec_t;

endpackage

// File: rtl/window_addr_gen.sv
// Row-major window walker: keeps the r/c counters, flags the final element and
// produces per-lane bank addresses plus an out-of-image pad flag.
module window_addr_gen #(
    parameter int IMAGE_WIDTH = 8,
    parameter int DEPTH       = 64,
    parameter int NUM_UNITS   = 2,
    parameter int ADDR_W      = 6,
    parameter int KDIM_W      = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic                              adv,
    input  logic [NUM_UNITS-1:0][ADDR_W-1:0]  base_addr,
    input  logic [KDIM_W-1:0]                 kernel_dim,
    output logic [NUM_UNITS-1:0][ADDR_W-1:0]  rd_idx,
    output logic [NUM_UNITS-1:0]              rd_pad,
    output logic                              rd_last
);

    // Four spare bits keep base + row offset + column from wrapping.
    localparam int SUM_W = ADDR_W + 4;

    logic [KDIM_W-1:0]                r_q, r_d;
    logic [KDIM_W-1:0]                c_q, c_d;
    logic [KDIM_W-1:0]                kdim_q, kdim_d;
    logic [NUM_UNITS-1:0][ADDR_W-1:0] base_q, base_d;
    logic                             at_row_end;

    assign at_row_end = (c_q == kdim_q - KDIM_W'(1));
    assign rd_last    = at_row_end && (r_q == kdim_q - KDIM_W'(1));

    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        kdim_d = kdim_q;
        base_d = base_q;
        if (load) begin
            r_d    = '0;
            c_d    = '0;
            kdim_d = kernel_dim;
            base_d = base_addr;
        end else if (adv) begin
            if (at_row_end) begin
                c_d = '0;
                r_d = r_q + KDIM_W'(1);
            end else begin
                c_d = c_q + KDIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            c_q    <= '0;
            kdim_q <= '0;
            base_q <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            kdim_q <= kdim_d;
            base_q <= base_d;
        end
    end

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
        logic [SUM_W-1:0] sum;
        assign sum = SUM_W'(base_q[gi])
                   + SUM_W'(r_q) * SUM_W'(IMAGE_WIDTH)
                   + SUM_W'(c_q);
        assign rd_pad[gi] = (sum >= SUM_W'(DEPTH));
        assign rd_idx[gi] = sum[ADDR_W-1:0];
    end

endmodule

// File: rtl/banked_window_memory.sv
// Banked image memory with a shared multi-lane write port and a sliding-window
// read sequencer that streams zero-padded elements over valid/ready.
module banked_window_memory
    import tpu_mem_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int IMAGE_WIDTH  = 8,
    parameter  int IMAGE_HEIGHT = 8,
    parameter  int NUM_UNITS    = 2,
    parameter  int NUM_BANKS    = 2,
    localparam int DEPTH        = IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int BANK_W       = bank_w(NUM_BANKS),
    localparam int ADDR_W       = addr_w(DEPTH),
    localparam int KDIM_W       = $clog2(IMAGE_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [BANK_W-1:0]                    wr_bank,
    input  logic [NUM_UNITS-1:0][ADDR_W-1:0]     wr_addr,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic                                 start,
    input  logic [BANK_W-1:0]                    rd_bank,
    input  logic [NUM_UNITS-1:0][ADDR_W-1:0]     base_addr,
    input  logic [KDIM_W-1:0]                    kernel_dim,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] out_data,
    output logic [NUM_UNITS-1:0]                 out_pad,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    state_e                               state_q, state_d;
    logic [BANK_W-1:0]                    bank_q, bank_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 out_last_q, out_last_d;
    logic [NUM_UNITS-1:0]                 out_pad_q, out_pad_d;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                                 done_q, done_d;
    logic                                 err_q, err_d;
    logic                                 adv;
    logic                                 load;

    logic [NUM_UNITS-1:0][ADDR_W-1:0]     rd_idx;
    logic [NUM_UNITS-1:0]                 rd_pad;
    logic                                 rd_last;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] rd_data;

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];

    window_addr_gen #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .DEPTH       (DEPTH),
        .NUM_UNITS   (NUM_UNITS),
        .ADDR_W      (ADDR_W),
        .KDIM_W      (KDIM_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .adv        (adv),
        .base_addr  (base_addr),
        .kernel_dim (kernel_dim),
        .rd_idx     (rd_idx),
        .rd_pad     (rd_pad),
        .rd_last    (rd_last)
    );

    // Later lanes overwrite earlier ones on duplicate addresses; reads in the
    // same cycle see the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                mem_q[wr_bank][wr_addr[i]] <= wr_data[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_rd
        assign rd_data[gi] = mem_q[bank_q][rd_idx[gi]];
    end

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_pad_d   = out_pad_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load        = 1'b0;
        adv         = (state_q == RUN) && (!out_valid_q || out_ready);

        if (out_valid_q && out_ready && !adv) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (kernel_dim == '0) begin
                        err_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        bank_d  = rd_bank;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    out_valid_d = 1'b1;
                    out_last_d  = rd_last;
                    out_pad_d   = rd_pad;
                    for (int i = 0; i < NUM_UNITS; i++) begin
                        out_data_d[i] = rd_pad[i] ? '0 : rd_data[i];
                    end
                    if (rd_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_valid_q && out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pad_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_pad_q   <= out_pad_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_pad   = out_pad_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/banked_window_memory.md
# banked_window_memory

Parametrised successor to the two-unit memory front end: NUM_BANKS independent image banks, each NUM_UNITS lanes wide, behind one shared write port and one sliding-window read sequencer. On a start pulse it streams a kernel_dim × kernel_dim window from a selected bank to the PE array. Each lane has its own base address. Out-of-image addresses are zero-padded, and the output uses a valid/ready handshake so the array can stall the stream.

## Interface
- DATA_WIDTH, 16: bits per element
- IMAGE_WIDTH, 8: row length, also the window row stride
- IMAGE_HEIGHT, 8: rows per bank; DEPTH = IMAGE_WIDTH*IMAGE_HEIGHT
- NUM_UNITS, 2: lanes per access
- NUM_BANKS, 2: independent image banks; BANK_W = max(1, $clog2(NUM_BANKS)), ADDR_W = $clog2(DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe
- wr_bank  in  BANK_W  target bank
- wr_addr  in  NUM_UNITS×ADDR_W  per-lane write address
- wr_data  in  NUM_UNITS×DATA_WIDTH  per-lane write data
- start  in  1  window request, sampled in IDLE only
- rd_bank  in  BANK_W  bank to stream, captured at start
- base_addr  in  NUM_UNITS×ADDR_W  per-lane window origin, captured at start
- kernel_dim  in  $clog2(IMAGE_WIDTH)  window side, captured at start
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  out_data holds an element
- out_data  out  NUM_UNITS×DATA_WIDTH  window element per lane
- out_pad  out  NUM_UNITS  lane element was out-of-image and forced to 0
- out_last  out  1  qualifies the final element of the window
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse when the last element handshakes
- err  out  1  one-cycle pulse on an illegal start

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE → RUN: start=1 and kernel_dim≠0. On this transition the block captures rd_bank, base_addr, kernel_dim and clears row/col counters r, c.
- start=1 with kernel_dim=0 in IDLE: err pulses and the FSM stays in IDLE.
- start=1 outside IDLE is ignored, with no err.
- Advance condition: adv = (state==RUN) && (!out_valid || out_ready).
- On adv, per lane i:
  - a_i = base_addr[i] + r*IMAGE_WIDTH + c, computed at ADDR_W+4 bits with no wrap.
  - a_i ≥ DEPTH: out_data[i] ← 0 and out_pad[i] ← 1.
  - otherwise: out_data[i] ← mem[bank][a_i] and out_pad[i] ← 0.
  - out_valid ← 1.
  - out_last ← (r==K-1 && c==K-1).
- Counters are row-major: c increments; on c==K-1, c←0 and r increments. After the last element is issued, RUN → FLUSH.
- FLUSH: once out_valid && out_ready, done pulses, out_valid←0, and the FSM returns to IDLE.
- In every state, out_valid && out_ready && !adv clears out_valid.
- Writes are accepted in any state: on wr_en, mem[wr_bank][wr_addr[i]] ← wr_data[i] for every lane i.
- Duplicate write addresses across lanes: the highest lane index wins.
- Read/write collision on the same bank and address in one cycle: the read returns old data.
- Memory contents are not reset.

## Timing
- Reset values: out_valid=0, out_pad=0, out_last=0, busy=0, done=0, err=0, out_data=0. The FSM goes to IDLE and counters go to 0.
- Reset mid-window abandons the stream immediately; the next cycle is IDLE.
- start sampled at edge E0 → busy=1 after E0. With out_ready held high, the first out_valid appears after E1, one element per cycle after that, K² elements total.
- done is high in the cycle after the final handshake edge, while busy is already 0. A new start is accepted in that same cycle.
- With out_ready=0, out_data and out_pad are held stable and the counters freeze.
- err and done are single-cycle and never overlap.

## Structure
- Package tpu_mem_pkg:
  - state enum {IDLE, RUN, FLUSH}
  - ADDR_W/BANK_W helper functions
  - lane vector typedefs for data and address
- Sub-module window_addr_gen: holds the r/c counters, the last-flag logic, per-lane address summation and the pad compare.
- The top holds the bank arrays, the write port and the output register/handshake.

## Test plan
- Fill bank 1 with mem[a]=a+100, base_addr={0,9}, K=3, out_ready=1. Expected:
  - lane0 returns 100,101,102,108,109,110,116,117,118
  - lane1 returns 109,110,111,117,118,119,125,126,127
  - out_last is high on the 9th element only; done follows one cycle later.
- Same stream with out_ready toggling 1,0,0,1,… → no element is lost or duplicated, and out_data stays stable while stalled.
- base_addr={62,0}, K=2 → lane0 elements 2 and 3 (addresses 70 and 71) are padded: out_pad[0]=1 and data=0.
- start with K=0 → err=1 for one cycle, busy stays 0, no out_valid. A start during RUN → ignored, no err.
- wr_en to the same bank and address as an in-flight read with a new value → the stream shows the old value. A later window shows the new value.
- Assert reset after 4 of 9 elements → the next cycle shows busy=0 and out_valid=0. A fresh start then returns the full 9-element window correctly.
